proj_idx_serializer: RTL

//  Receiving end of the sorter output interface. Captures the parallel

---
 rtl/proj_pkg.sv | 8 +
 rtl/proj_idx_serializer.sv | 51 +++++
 2 files changed

// File: rtl/proj_pkg.sv
// proj_pkg: shared sizes and types for the sorter-to-extender path
package proj_pkg;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int INDICE_LEN = 8;
  typedef logic [INDICE_LEN-1:0] idx_t;
  typedef idx_t [SORTER_EXTENDER_INDICES_COUNT-1:0] idx_vec_t;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ser_state_e;
endpackage

// File: rtl/proj_idx_serializer.sv
// proj_idx_serializer: captures a sorted index vector and replays it one index per beat
module proj_idx_serializer #(
  parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
  parameter int INDICE_LEN = proj_pkg::INDICE_LEN
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_smallest_idx,
  input  logic                                in_sort_valid,
  output logic [INDICE_LEN-1:0]               out_index,
  output logic                                out_valid,
  output logic                                out_last,
  input  logic                                in_ready,
  output logic                                out_busy,
  output logic                                out_drop
);
  import proj_pkg::*;
  localparam int PW = INDICES_COUNT > 1 ? $clog2(INDICES_COUNT) : 1;
  ser_state_e state;
  logic [PW-1:0] ptr;
  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] buffer;
  logic at_last, xfer, last_xfer, capture;
  // beat decode: outputs come straight from the state, pointer and buffer registers
  always_comb begin
    at_last = ptr == PW'(INDICES_COUNT - 1);
    xfer = state == SEND && in_ready;
    last_xfer = xfer && at_last;
    capture = in_sort_valid && (state == IDLE || last_xfer);
    out_valid = state == SEND;
    out_busy = state == SEND;
    out_last = state == SEND && at_last;
    out_index = buffer[ptr];
  end
  // frame capture, pointer advance and drop reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      buffer <= '0;
      out_drop <= 1'b0;
    end else begin
      out_drop <= in_sort_valid && state == SEND && !last_xfer;
      if (capture) begin
        buffer <= in_smallest_idx;
        ptr <= '0;
        state <= SEND;
      end else if (last_xfer) state <= IDLE;
      else if (xfer) ptr <= ptr + 1'b1;
    end
  end
endmodule
